// File: rtl/tx_mux.sv
// Transmit-side symbol framer: wraps data-layer packets in STP/SDP ... END (EDB on underrun),
// fills gaps with IDL and inserts COM+SKP ordered sets between packets on a periodic timer.
module tx_mux #(
  parameter int SKP_INTERVAL = 16,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] tx_Data,
  input  logic       tx_Valid,
  input  logic       tx_Last,
  input  logic       tx_Type,
  output logic       tx_Ready,
  output logic [7:0] tx_out,
  output logic       tx_K,
  output logic       tx_Underrun
);

  localparam int TW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int IW = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(SKP_COUNT - 1);

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_END,
    S_SKP
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      out_reg, out_next;
  logic            k_reg, k_next;
  logic            underrun_reg, underrun_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            pending_reg, pending_next;
  logic [IW-1:0]   idx_reg, idx_next;

  assign tx_Ready    = enb & (state_reg == S_DATA);
  assign tx_out      = out_reg;
  assign tx_K        = k_reg;
  assign tx_Underrun = underrun_reg;

  always_comb begin
    state_next    = state_reg;
    out_next      = SYM_IDL;
    k_next        = 1'b1;
    underrun_next = 1'b0;
    timer_next    = timer_reg;
    pending_next  = pending_reg;
    idx_next      = idx_reg;

    // The timer is frozen while an ordered set is being sent; the request stays sticky.
    if (state_reg != S_SKP) begin
      if (timer_reg == TIMER_LAST) begin
        timer_next   = '0;
        pending_next = 1'b1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (pending_reg) begin
          out_next   = SYM_COM;
          idx_next   = '0;
          state_next = S_SKP;
        end else if (tx_Valid) begin
          out_next   = tx_Type ? SYM_STP : SYM_SDP;
          state_next = S_DATA;
        end else begin
          out_next = SYM_IDL;
        end
      end
      S_DATA: begin
        if (tx_Valid) begin
          out_next = tx_Data;
          k_next   = 1'b0;
          if (tx_Last) state_next = S_END;
        end else begin
          out_next      = SYM_EDB;
          underrun_next = 1'b1;
          state_next    = S_IDLE;
        end
      end
      S_END: begin
        out_next   = SYM_END;
        state_next = S_IDLE;
      end
      S_SKP: begin
        out_next = SYM_SKP;
        if (idx_reg == IDX_LAST) begin
          state_next   = S_IDLE;
          pending_next = 1'b0;
          timer_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      out_reg      <= 8'h00;
      k_reg        <= 1'b0;
      underrun_reg <= 1'b0;
      timer_reg    <= '0;
      pending_reg  <= 1'b0;
      idx_reg      <= '0;
    end else if (enb) begin
      state_reg    <= state_next;
      out_reg      <= out_next;
      k_reg        <= k_next;
      underrun_reg <= underrun_next;
      timer_reg    <= timer_next;
      pending_reg  <= pending_next;
      idx_reg      <= idx_next;
    end
  end

endmodule
